// File: rtl/hdmi_capture_ctrl.sv
// Pixel-clock capture sequencer: chooses which frames are copied, rotates the
// target frame buffer around a reader lock and measures the incoming geometry.
module hdmi_capture_ctrl #(
    parameter int unsigned AW    = 24,
    parameter int unsigned XBITS = 13,
    parameter int unsigned YBITS = 11
) (
    input  logic             i_pix_clk,
    input  logic             i_reset,
    input  logic             i_pix_eof,
    input  logic             i_pix_eol,
    input  logic             i_pix_valid,
    input  logic             i_en,
    input  logic             i_single,
    input  logic             i_arm,
    input  logic [3:0]       i_decim,
    input  logic [1:0]       i_nbufs,
    input  logic [AW-1:0]    i_base,
    input  logic [AW-1:0]    i_stride,
    input  logic             i_rd_busy,
    input  logic [1:0]       i_rd_buf,
    output logic             o_copy_en,
    output logic [AW-1:0]    o_first_address,
    output logic [1:0]       o_wr_buf,
    output logic [1:0]       o_last_buf,
    output logic             o_frame_stb,
    output logic [15:0]      o_frame_count,
    output logic             o_busy,
    output logic [XBITS-1:0] o_npix,
    output logic [YBITS-1:0] o_nlines,
    output logic             o_geom_ok
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_CAPTURE,
        S_SKIP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            arm_q, arm_d;
    logic [3:0]      skip_q, skip_d;
    logic            sel_en;
    logic            enter_cap;

    logic            copy_en_q;
    logic [AW-1:0]   addr_q;
    logic [1:0]      wr_buf_q;
    logic [1:0]      last_buf_q;
    logic            stb_q;
    logic [15:0]     count_q;

    logic [1:0]      cand_buf;
    logic [1:0]      nxt_buf;
    logic [AW-1:0]   stride_x;

    // (cur + 1) mod (nb + 1), exact even if nb shrank below cur
    function automatic logic [1:0] buf_step(input logic [1:0] cur, input logic [1:0] nb);
        logic [2:0] v;
        logic [2:0] m;
        v = {1'b0, cur} + 3'd1;
        m = {1'b0, nb} + 3'd1;
        for (int unsigned k = 0; k < 32'd4; k++) begin
            if (v >= m) v = v - m;
        end
        return v[1:0];
    endfunction

    assign cand_buf = buf_step(wr_buf_q, i_nbufs);
    assign nxt_buf  = (i_rd_busy && (cand_buf == i_rd_buf)) ? buf_step(cand_buf, i_nbufs) : cand_buf;
    assign stride_x = ({AW{nxt_buf[0]}} & i_stride) + ({AW{nxt_buf[1]}} & {i_stride[AW-2:0], 1'b0});

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        sel_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_en && (!i_single || arm_q)) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (i_pix_eof) begin
                    state_d = S_CAPTURE;
                    sel_en  = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (i_pix_eof) begin
                    if (!i_en) begin
                        state_d = S_IDLE;
                    end else if (i_single) begin
                        state_d = S_DONE;
                    end else if (i_decim != '0) begin
                        state_d = S_SKIP;
                        skip_d  = i_decim;
                    end else begin
                        sel_en = 1'b1;
                    end
                end
            end
            S_SKIP: begin
                if (i_pix_eof) begin
                    if (!i_en) begin
                        state_d = S_IDLE;
                    end else if (skip_q == 4'd1) begin
                        state_d = S_CAPTURE;
                        sel_en  = 1'b1;
                    end else begin
                        skip_d = skip_q - 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (arm_q) state_d = S_SYNC;
                else if (i_pix_eof && !i_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new arm request beats a same-cycle clear
    assign enter_cap = sel_en && (state_q != S_CAPTURE);
    assign arm_d     = i_arm | (arm_q & (state_q != S_IDLE) & !enter_cap);

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            arm_q      <= 1'b0;
            skip_q     <= '0;
            copy_en_q  <= 1'b0;
            addr_q     <= '0;
            wr_buf_q   <= '0;
            last_buf_q <= '0;
            stb_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q   <= state_d;
            arm_q     <= arm_d;
            skip_q    <= skip_d;
            copy_en_q <= (state_d == S_CAPTURE);
            stb_q     <= (state_q == S_CAPTURE) && i_pix_eof;
            if ((state_q == S_CAPTURE) && i_pix_eof) begin
                last_buf_q <= wr_buf_q;
                count_q    <= count_q + 16'd1;
            end
            if (sel_en) begin
                wr_buf_q <= nxt_buf;
                addr_q   <= i_base + stride_x;
            end
        end
    end

    // Geometry measurement runs regardless of capture state
    logic [XBITS-1:0] pcnt_q, pcnt_inc, npix_cur_q, npix_new, npix_q;
    logic [YBITS-1:0] lcnt_q, lcnt_inc, nlines_q;
    logic             geom_ok_q;

    assign pcnt_inc = (i_pix_valid && (pcnt_q != '1)) ? pcnt_q + 1'b1 : pcnt_q;
    assign npix_new = i_pix_eol ? pcnt_inc : npix_cur_q;
    assign lcnt_inc = (i_pix_eol && (lcnt_q != '1)) ? lcnt_q + 1'b1 : lcnt_q;

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            pcnt_q     <= '0;
            npix_cur_q <= '0;
            lcnt_q     <= '0;
            npix_q     <= '0;
            nlines_q   <= '0;
            geom_ok_q  <= 1'b0;
        end else begin
            pcnt_q     <= i_pix_eol ? '0 : pcnt_inc;
            npix_cur_q <= npix_new;
            if (i_pix_eof) begin
                lcnt_q    <= '0;
                npix_q    <= npix_new;
                nlines_q  <= lcnt_inc;
                geom_ok_q <= (npix_new == npix_q) && (lcnt_inc == nlines_q) &&
                             (npix_new != '0) && (lcnt_inc != '0);
            end else begin
                lcnt_q <= lcnt_inc;
            end
        end
    end

    assign o_copy_en       = copy_en_q;
    assign o_first_address = addr_q;
    assign o_wr_buf        = wr_buf_q;
    assign o_last_buf      = last_buf_q;
    assign o_frame_stb     = stb_q;
    assign o_frame_count   = count_q;
    assign o_busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_npix          = npix_q;
    assign o_nlines        = nlines_q;
    assign o_geom_ok       = geom_ok_q;

endmodule

// File: tb/tb_hdmi_capture_ctrl.sv
// Bench for hdmi_capture_ctrl: frame-rule reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hdmi_capture_ctrl;
    localparam int AW    = 24;
    localparam int XBITS = 13;
    localparam int YBITS = 11;
    localparam int XMAX  = (1 << XBITS) - 1;
    localparam int YMAX  = (1 << YBITS) - 1;

    localparam int PH_IDLE = 0;
    localparam int PH_SYNC = 1;
    localparam int PH_CAP  = 2;
    localparam int PH_SKIP = 3;
    localparam int PH_DONE = 4;

    logic             clk = 1'b0;
    logic             rst, eof, eol, valid, en, single, arm, rd_busy;
    logic [3:0]       decim;
    logic [1:0]       nbufs, rd_buf;
    logic [AW-1:0]    base, stride;
    logic             o_copy_en, o_frame_stb, o_busy, o_geom_ok;
    logic [AW-1:0]    o_first_address;
    logic [1:0]       o_wr_buf, o_last_buf;
    logic [15:0]      o_frame_count;
    logic [XBITS-1:0] o_npix;
    logic [YBITS-1:0] o_nlines;

    int checks = 0;
    int errors = 0;
    int stb_seen = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    hdmi_capture_ctrl #(.AW(AW), .XBITS(XBITS), .YBITS(YBITS)) dut (
        .i_pix_clk(clk), .i_reset(rst), .i_pix_eof(eof), .i_pix_eol(eol),
        .i_pix_valid(valid), .i_en(en), .i_single(single), .i_arm(arm),
        .i_decim(decim), .i_nbufs(nbufs), .i_base(base), .i_stride(stride),
        .i_rd_busy(rd_busy), .i_rd_buf(rd_buf),
        .o_copy_en(o_copy_en), .o_first_address(o_first_address),
        .o_wr_buf(o_wr_buf), .o_last_buf(o_last_buf), .o_frame_stb(o_frame_stb),
        .o_frame_count(o_frame_count), .o_busy(o_busy), .o_npix(o_npix),
        .o_nlines(o_nlines), .o_geom_ok(o_geom_ok)
    );

    // ---------------- reference model ----------------
    int            ph, m_skip, m_px, m_lines, m_linepx, m_wr;
    bit            m_arm;
    logic          e_copy, e_stb, e_busy, e_ok;
    logic [1:0]    e_wr, e_last;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_cnt;
    logic [XBITS-1:0] e_npix;
    logic [YBITS-1:0] e_nlines;

    function automatic int next_buf(int cur, int nb, bit lk, int rd);
        int n = (cur + 1) % (nb + 1);
        if (lk && n == rd) n = (n + 1) % (nb + 1);
        return n;
    endfunction

    always @(posedge clk) begin : model
        int  old_ph;
        bit  sel, stb_now;
        longint a;
        if (rst) begin
            ph = PH_IDLE; m_skip = 0; m_px = 0; m_lines = 0; m_linepx = 0; m_wr = 0; m_arm = 0;
            e_copy = 0; e_stb = 0; e_busy = 0; e_ok = 0; e_wr = 0; e_last = 0;
            e_addr = '0; e_cnt = '0; e_npix = '0; e_nlines = '0;
            chk_on = 1;
        end else begin
            old_ph  = ph;
            sel     = 0;
            stb_now = (ph == PH_CAP) && eof;
            if (ph == PH_IDLE) begin
                if (en && (!single || m_arm)) ph = PH_SYNC;
            end else if (ph == PH_DONE && m_arm) begin
                ph = PH_SYNC;
            end else if (eof) begin
                if (ph != PH_SYNC && !en) ph = PH_IDLE;
                else if (ph == PH_SYNC) sel = 1;
                else if (ph == PH_CAP) begin
                    if (single) ph = PH_DONE;
                    else if (decim != 0) begin ph = PH_SKIP; m_skip = int'(decim); end
                    else sel = 1;
                end else if (ph == PH_SKIP) begin
                    if (m_skip == 1) sel = 1;
                    else m_skip = m_skip - 1;
                end
            end
            e_stb = stb_now;
            if (stb_now) begin
                e_last = e_wr;
                e_cnt  = e_cnt + 16'd1;
            end
            if (sel) begin
                m_wr   = next_buf(m_wr, int'(nbufs), rd_busy, int'(rd_buf));
                a      = longint'(base) + longint'(m_wr) * longint'(stride);
                e_addr = a[AW-1:0];
                e_wr   = m_wr[1:0];
                ph     = PH_CAP;
            end
            if (arm) m_arm = 1;
            else if (old_ph == PH_IDLE || (sel && old_ph != PH_CAP)) m_arm = 0;
            e_copy = (ph == PH_CAP);
            e_busy = (ph == PH_SYNC) || (ph == PH_CAP) || (ph == PH_SKIP);
            // geometry
            if (valid && m_px < XMAX) m_px++;
            if (eol) begin
                m_linepx = m_px;
                m_px = 0;
                if (m_lines < YMAX) m_lines++;
            end
            if (eof) begin
                e_ok = (m_linepx == int'(e_npix)) && (m_lines == int'(e_nlines)) &&
                       (m_linepx != 0) && (m_lines != 0);
                e_npix   = m_linepx[XBITS-1:0];
                e_nlines = m_lines[YBITS-1:0];
                m_lines  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (o_frame_stb === 1'b1) stb_seen++;
        if (chk_on) begin
            checks++;
            if (o_copy_en !== e_copy || o_wr_buf !== e_wr || o_first_address !== e_addr ||
                o_last_buf !== e_last || o_frame_stb !== e_stb || o_frame_count !== e_cnt ||
                o_busy !== e_busy || o_npix !== e_npix || o_nlines !== e_nlines || o_geom_ok !== e_ok) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got copy=%b wr=%0d addr=%h last=%0d stb=%b cnt=%0d busy=%b npix=%0d nl=%0d ok=%b | expected copy=%b wr=%0d addr=%h last=%0d stb=%b cnt=%0d busy=%b npix=%0d nl=%0d ok=%b",
                         $time, o_copy_en, o_wr_buf, o_first_address, o_last_buf, o_frame_stb, o_frame_count,
                         o_busy, o_npix, o_nlines, o_geom_ok, e_copy, e_wr, e_addr, e_last, e_stb, e_cnt,
                         e_busy, e_npix, e_nlines, e_ok);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic          rec_copy[$];
    logic [1:0]    rec_wr[$];
    logic [AW-1:0] rec_addr[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 0; eol = 0; eof = 0; arm = 0;
        end
    endtask

    // Each line: one blank cycle then px valid cycles, eol on the last valid one
    task automatic frame(input int nl, input int px, input bit do_eof);
        for (int l = 0; l < nl; l++) begin
            @(negedge clk);
            if (l == 0) begin
                rec_copy.push_back(o_copy_en);
                rec_wr.push_back(o_wr_buf);
                rec_addr.push_back(o_first_address);
            end
            valid = 0; eol = 0; eof = 0;
            for (int p = 0; p < px; p++) begin
                @(negedge clk);
                valid = 1;
                eol   = (p == px - 1);
                eof   = do_eof && (l == nl - 1) && (p == px - 1);
            end
        end
        @(negedge clk);
        valid = 0; eol = 0; eof = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        rec_copy.delete(); rec_wr.delete(); rec_addr.delete();
    endtask

    task automatic pulse_arm();
        @(negedge clk); arm = 1;
        @(negedge clk); arm = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [8:0] pat;
        rst = 1; eof = 0; eol = 0; valid = 0; en = 0; single = 0; arm = 0;
        decim = 0; nbufs = 2; base = 24'h1000; stride = 24'h400; rd_busy = 0; rd_buf = 0;
        repeat (3) @(negedge clk);
        check("reset_copy_en", o_copy_en, 0);
        check("reset_addr", o_first_address, 0);
        check("reset_count", o_frame_count, 0);
        check("reset_busy", o_busy, 0);
        rst = 0;

        // continuous rotation over 3 buffers
        en = 1;
        do_reset();
        s0 = stb_seen;
        repeat (5) frame(4, 8, 1);
        idle(2);
        check("rot_copy_f0", rec_copy[0], 0);
        check("rot_addr_f1", rec_addr[1], 24'h1400);
        check("rot_addr_f2", rec_addr[2], 24'h1800);
        check("rot_addr_f3", rec_addr[3], 24'h1000);
        check("rot_addr_f4", rec_addr[4], 24'h1400);
        check("rot_wr_f3", rec_wr[3], 0);
        check("rot_stb_count", stb_seen - s0, 4);
        check("rot_frame_count", o_frame_count, 4);
        check("rot_last_buf", o_last_buf, 1);

        // decimation by 2
        decim = 2;
        do_reset();
        s0 = stb_seen;
        repeat (9) frame(4, 8, 1);
        idle(2);
        pat = 9'b010010010;
        for (int i = 0; i < 9; i++) check($sformatf("decim_copy_f%0d", i), rec_copy[i], pat[i]);
        check("decim_stb_count", stb_seen - s0, 3);
        decim = 0;

        // one-shot captures
        single = 1;
        do_reset();
        idle(4);
        check("single_idle_busy", o_busy, 0);
        pulse_arm();
        repeat (3) frame(4, 8, 1);
        idle(2);
        check("single1_copy_f1", rec_copy[1], 1);
        check("single1_copy_f2", rec_copy[2], 0);
        check("single1_busy", o_busy, 0);
        check("single1_count", o_frame_count, 1);
        pulse_arm();
        repeat (3) frame(4, 8, 1);
        idle(2);
        check("single2_copy_f4", rec_copy[4], 1);
        check("single2_copy_f5", rec_copy[5], 0);
        check("single2_count", o_frame_count, 2);
        single = 0;

        // reader lock skipping
        rd_busy = 1; rd_buf = 1; nbufs = 2;
        do_reset();
        repeat (2) frame(4, 8, 1);
        check("lock3_wr", rec_wr[1], 2);
        check("lock3_addr", rec_addr[1], 24'h1800);
        nbufs = 1;
        do_reset();
        repeat (3) frame(4, 8, 1);
        check("lock2_wr_f1", rec_wr[1], 0);
        check("lock2_wr_f2", rec_wr[2], 0);
        nbufs = 0; rd_buf = 0;
        do_reset();
        repeat (3) frame(4, 8, 1);
        check("lock1_wr_f2", rec_wr[2], 0);
        check("lock1_copy_f2", rec_copy[2], 1);
        check("lock1_addr_f2", rec_addr[2], 24'h1000);
        rd_busy = 0; nbufs = 2;

        // reset in the middle of a captured frame, then enable dropped mid-frame
        do_reset();
        frame(4, 8, 1);
        frame(2, 8, 0);
        check("midrst_copy_before", o_copy_en, 1);
        s0 = stb_seen;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        check("midrst_copy_after", o_copy_en, 0);
        check("midrst_wr", o_wr_buf, 0);
        check("midrst_npix", o_npix, 0);
        frame(2, 8, 1);
        idle(2);
        check("midrst_no_stb", stb_seen - s0, 0);
        frame(2, 8, 0);
        en = 0;
        frame(2, 8, 1);
        idle(2);
        check("endrop_stb", stb_seen - s0, 1);
        check("endrop_count", o_frame_count, 1);
        check("endrop_busy", o_busy, 0);
        frame(4, 8, 1);
        check("endrop_copy_next", rec_copy[rec_copy.size() - 1], 0);

        // geometry
        frame(48, 64, 1); idle(1);
        check("geom_a1_npix", o_npix, 64);
        check("geom_a1_nlines", o_nlines, 48);
        check("geom_a1_ok", o_geom_ok, 0);
        frame(48, 64, 1); idle(1);
        check("geom_a2_ok", o_geom_ok, 1);
        frame(48, 80, 1); idle(1);
        check("geom_b1_npix", o_npix, 80);
        check("geom_b1_ok", o_geom_ok, 0);
        frame(48, 80, 1); idle(1);
        check("geom_b2_ok", o_geom_ok, 1);
        frame(1, 8195, 1); idle(1);
        check("geom_pix_sat", o_npix, XMAX);
        check("geom_pix_sat_lines", o_nlines, 1);
        frame(2050, 1, 1); idle(1);
        check("geom_line_sat", o_nlines, YMAX);
        check("geom_line_sat_npix", o_npix, 1);
        check("geom_line_sat_ok", o_geom_ok, 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
